operand_decode: RTL

OPERAND_DECODE -- requirements
Module: operand_decode

---
 rtl/cpu_decode_pkg.sv | 40 ++++
 rtl/imm_ext.sv | 34 +++
 rtl/operand_decode.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_decode_pkg.sv
// Shared decode definitions: opcodes, operand-B select encodings, skid-buffer
// states and the decoded entry carried through the buffer.
package cpu_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_IMM  = 2'b01;
  localparam logic [1:0] SEL_ZIMM = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] zimm;
    logic        illegal;
  } entry_t;

  // Value an output slot takes when nothing valid is presented.
  localparam entry_t ENTRY_IDLE = '{sel: SEL_NONE, imm: 32'h0, zimm: 32'h0, illegal: 1'b0};

endpackage

// File: rtl/imm_ext.sv
// Combinational opcode decode plus sign/zero extension of imm16.
module imm_ext
  import cpu_decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [0:5]        opcode,
  input  logic [0:15]       imm16,
  output logic [0:1]        sel,
  output logic [0:DATA_W-1] imm,
  output logic [0:DATA_W-1] zimm,
  output logic              illegal
);

  // Extensions are produced for every opcode, legal or not.
  assign imm  = {{(DATA_W-16){imm16[0]}}, imm16};
  assign zimm = {{(DATA_W-16){1'b0}}, imm16};

  // Opcode -> operand-B select; anything unlisted is flagged illegal.
  always_comb begin
    sel     = SEL_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE:                         sel = SEL_REG;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: sel = SEL_IMM;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:                 sel = SEL_ZIMM;
      default: begin
        sel     = SEL_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/operand_decode.sv
// Operand decoder: decodes at the input, then holds results in a 2-entry
// skid buffer (head drives the outputs, skid catches one extra under stall).
module operand_decode
  import cpu_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:1]        sel_alu,
  output logic [0:DATA_W-1] Imm,
  output logic [0:DATA_W-1] ZImm,
  output logic              illegal,
  output logic [0:CNT_W-1]  illegal_cnt
);

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  entry_t           dec;
  logic [0:1]       dec_sel;
  logic [0:31]      dec_imm, dec_zimm;
  logic             dec_ill;
  logic             accept, xfer;

  imm_ext #(.DATA_W(32)) u_imm_ext (
    .opcode  (instr[0:5]),
    .imm16   (instr[16:31]),
    .sel     (dec_sel),
    .imm     (dec_imm),
    .zimm    (dec_zimm),
    .illegal (dec_ill)
  );

  assign dec    = '{sel: dec_sel, imm: dec_imm, zimm: dec_zimm, illegal: dec_ill};
  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid && out_ready;

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign sel_alu     = head_q.sel;
  assign Imm         = head_q.imm;
  assign ZImm        = head_q.zimm;
  assign illegal     = head_q.illegal;
  assign illegal_cnt = cnt_q;

  // Skid-buffer next state; the head slot is parked at SEL_NONE/!illegal
  // whenever it empties so the idle outputs need no extra muxing.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d = ST_ONE;
        head_d  = dec;
      end
      ST_ONE: begin
        if (accept && !xfer) begin
          state_d = ST_FULL;
          skid_d  = dec;
        end else if (!accept && xfer) begin
          state_d        = ST_EMPTY;
          head_d.sel     = SEL_NONE;
          head_d.illegal = 1'b0;
        end else if (accept && xfer) begin
          head_d = dec;
        end
      end
      ST_FULL: if (xfer) begin
        state_d = ST_ONE;
        head_d  = skid_q;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
    // Flush drops everything, including an instruction offered this cycle,
    // so that instruction is not counted either.
    if (flush) begin
      state_d        = ST_EMPTY;
      head_d.sel     = SEL_NONE;
      head_d.illegal = 1'b0;
      cnt_d          = cnt_q;
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State registers; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      head_q     <= ENTRY_IDLE;
      skid_q     <= ENTRY_IDLE;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
